// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Contents: FSM state enum, default widths, channel-count helper, minimum dwell.
// Optional feature macro: SCAN_MAJORITY_EN (selects the 2-of-3 sampling minimum dwell).
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int SEL_W_DEF   = 2;
    localparam int DWELL_W_DEF = 4;

    // Three samples are needed for a 2-of-3 vote, so the dwell cannot go below 3.
`ifdef SCAN_MAJORITY_EN
    localparam int MIN_DWELL = 3;
`else
    localparam int MIN_DWELL = 1;
`endif

    function automatic int nch(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Per-channel dwell counter for the scan sequencer.
// Ports: clk/rst, load (latch dwell and start a new frame), step (advance while scanning),
//        dwell (raw request), last (final cycle of a channel), win (last-3 window,
//        present only when SCAN_MAJORITY_EN is defined).
module scan_dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MAJORITY_EN
    output logic               win,
`endif
    output logic               last
);

    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] eff;

    // Requests shorter than the minimum are stretched rather than rejected.
    always_comb begin
        eff = dwell;
        if (dwell < DWELL_W'(MIN_DWELL)) begin
            eff = DWELL_W'(MIN_DWELL);
        end
    end

    // cnt counts down to 0; 0 marks the sampling cycle of the current channel.
    // The latched dwell is reused for every channel of the frame, so a change
    // of the dwell input mid-frame has no effect until the next frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            cnt     <= '0;
        end else if (load) begin
            dwell_q <= eff;
            cnt     <= eff - DWELL_W'(1);
        end else if (step) begin
            if (cnt == '0) begin
                cnt <= dwell_q - DWELL_W'(1);
            end else begin
                cnt <= cnt - DWELL_W'(1);
            end
        end
    end

    assign last = (cnt == '0);

`ifdef SCAN_MAJORITY_EN
    assign win = (cnt < DWELL_W'(3));
`endif

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 bit-select mux channel by channel and assembles the samples into a frame.
// Ports: clk/rst (sync, active high), en, dwell in; sel_out to mux, mux_bit back;
//        frame_data/frame_valid/frame_ready output handshake; busy, overrun (sticky) status.
// Optional feature macro: SCAN_MAJORITY_EN (2-of-3 vote over the last three dwell cycles).
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [SEL_W-1:0]       sel_out,
    input  logic                   mux_bit,
    output logic [(1<<SEL_W)-1:0]  frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int NCH = nch(SEL_W);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

    state_t           state;
    logic [SEL_W-1:0] ch;
    logic [NCH-1:0]   shadow;
    logic [NCH-1:0]   frame;
    logic             samp_bit;
    logic             last;
    logic             start;
    logic             commit;
    logic             load;
    logic             step;

    // The channel index register drives the mux directly; it only leaves
    // LAST_CH through the commit path, so it never exceeds NCH-1.
    assign sel_out = ch;

    assign start  = (state == IDLE) && en;
    assign commit = (state == SCAN) && last && (ch == LAST_CH);
    // A commit with en still high starts the next frame with no gap cycle.
    assign load   = start || (commit && en);
    assign step   = (state == SCAN);

`ifdef SCAN_MAJORITY_EN
    logic       win;
    logic [1:0] hist;

    scan_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .dwell (dwell),
        .win   (win),
        .last  (last)
    );

    // hist holds the two samples before the last cycle; the live bit is the third vote.
    assign samp_bit = (hist[1] & hist[0]) | (hist[1] & mux_bit) | (hist[0] & mux_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (step && win) begin
            hist <= {hist[0], mux_bit};
        end
    end
`else
    scan_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .dwell (dwell),
        .last  (last)
    );

    assign samp_bit = mux_bit;
`endif

    // The final sample is merged combinationally so the frame can be committed
    // on the same cycle it is taken.
    always_comb begin
        frame          = shadow;
        frame[NCH-1]   = samp_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Output register: a commit takes priority over a plain handshake so a
            // frame accepted in the same cycle as a new commit keeps valid high.
            if (commit) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= frame;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    ch <= '0;
                    if (en) begin
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (last) begin
                        shadow[ch] <= samp_bit;
                        if (ch != LAST_CH) begin
                            ch <= ch + SEL_W'(1);
                        end else begin
                            ch <= '0;
                            if (!en) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer with a frame-position reference model.
// Ports: none; drives the DUT and models the mux as mux_bit = data[sel_out].
// Optional feature macro: SCAN_MAJORITY_EN (model switches to a 2-of-3 vote, min dwell 3).
module tb_mux_scan_sequencer;

    localparam int NCH = 4;
`ifdef SCAN_MAJORITY_EN
    localparam int MIN = 3;
`else
    localparam int MIN = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] dwell = 4'd1;
    logic       frame_ready = 1'b1;
    logic [1:0] sel_out;
    logic       mux_bit;
    logic [3:0] frame_data;
    logic       frame_valid;
    logic       busy;
    logic       overrun;

    logic [3:0] data = 4'b0000;
    logic       ovr = 1'b0;
    logic       pat = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [1:0] sel_log [0:40];

    always #5 clk = ~clk;

    assign mux_bit = ovr ? pat : data[sel_out];

    mux_scan_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dwell       (dwell),
        .sel_out     (sel_out),
        .mux_bit     (mux_bit),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [3:0] d);
        return (int'(d) < MIN) ? MIN : int'(d);
    endfunction

    // Reference model: position m_t within the frame, channel = m_t / D,
    // sample taken on the last D-cycle of each channel.
    bit       m_busy, m_fv, m_ov;
    int       m_t, m_d, ones;
    bit [3:0] m_fd, m_samp;

    always @(posedge clk) begin
        int sel, pos;
        bit mb, old_fv, com;
        if (rst) begin
            m_busy = 0; m_fv = 0; m_ov = 0; m_t = 0; m_d = 1;
            m_fd = 0; m_samp = 0; ones = 0;
        end else begin
            old_fv = m_fv;
            com = 0;
            if (!m_busy) begin
                if (en) begin
                    m_busy = 1; m_t = 0; m_d = eff(dwell);
                end
            end else begin
                sel = m_t / m_d;
                pos = m_t % m_d;
                mb  = ovr ? pat : data[sel];
                if (pos == m_d - MIN) ones = 0;
                if (pos >= m_d - MIN) ones += int'(mb);
                if (pos == m_d - 1) m_samp[sel] = (ones * 2 > MIN);
                if (m_t == NCH * m_d - 1) begin
                    com = 1;
                    m_t = 0;
                    if (en) m_d = eff(dwell);
                    else m_busy = 0;
                end else begin
                    m_t++;
                end
            end
            if (com) begin
                if (!old_fv || frame_ready) begin
                    m_fd = m_samp; m_fv = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (old_fv && frame_ready) begin
                m_fv = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("sel_out",     32'(sel_out),     m_busy ? 32'(m_t / m_d) : 32'd0);
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_data",  32'(frame_data),  32'(m_fd));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("overrun",     32'(overrun),     32'(m_ov));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_frame(input logic [3:0] dw, output int vc);
        dwell = dw;
        en = 1'b1;
        step(1);
        en = 1'b0;
        vc = 1;
        sel_log[1] = sel_out;
        while (frame_valid !== 1'b1 && vc < 40) begin
            step(1);
            vc++;
            sel_log[vc] = sel_out;
        end
    endtask

    task automatic run_pat(input logic [2:0] p, output logic fv, output logic [3:0] fd);
        dwell = 4'd3;
        en = 1'b1;
        pat = 1'b0;
        step(1);
        en = 1'b0;
        pat = p[2];
        step(1);
        pat = p[1];
        step(1);
        pat = p[0];
        step(1);
        pat = 1'b0;
        step(9);
        fv = frame_valid;
        fd = frame_data;
    endtask

    initial begin
        int v0, v1, v3, seen;
        logic pfv;
        logic [3:0] pfd;

        step(2);
        rst = 1'b0;

        // Reset in the middle of a scan aborts the frame.
        data = 4'b1111;
        dwell = 4'd3;
        en = 1'b1;
        step(1);
        en = 1'b0;
        step(6);
        chk("t1_sel_before_rst", 32'(sel_out), 32'd2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("t1_sel_rst", 32'(sel_out), 32'd0);
        chk("t1_valid_rst", 32'(frame_valid), 32'd0);
        chk("t1_data_rst", 32'(frame_data), 32'd0);
        chk("t1_busy_rst", 32'(busy), 32'd0);
        chk("t1_ovr_rst", 32'(overrun), 32'd0);
        seen = 0;
        repeat (20) begin
            step(1);
            seen |= int'(frame_valid);
        end
        chk("t1_no_valid", 32'(seen), 32'd0);

        // Single frame, dwell 1.
        data = 4'b1010;
        dwell = 4'd1;
        frame_ready = 1'b1;
        en = 1'b1;
        step(1);
        en = 1'b0;
        chk("t2_sel_c1", 32'(sel_out), 32'd0);
        chk("t2_busy_c1", 32'(busy), 32'd1);
        step(1);
        chk("t2_sel_c2", 32'(sel_out), 32'd1);
        step(1);
        chk("t2_sel_c3", 32'(sel_out), 32'd2);
        step(1);
        chk("t2_sel_c4", 32'(sel_out), 32'd3);
        step(1);
        chk("t2_data_c5", 32'(frame_data), 32'hA);
        chk("t2_valid_c5", 32'(frame_valid), 32'd1);
        chk("t2_busy_c5", 32'(busy), 32'd0);
        step(2);

        // Dwell 0 behaves as dwell 1; dwell 3 holds each select for 3 cycles.
        run_frame(4'd0, v0);
        step(2);
        run_frame(4'd1, v1);
        step(2);
        run_frame(4'd3, v3);
        chk("t3_valid_cycle_d0", 32'(v0), 32'd5);
        chk("t3_valid_cycle_d1", 32'(v1), 32'd5);
        chk("t3_valid_cycle_d3", 32'(v3), 32'd13);
        chk("t3_sel_c3", 32'(sel_log[3]), 32'd0);
        chk("t3_sel_c4", 32'(sel_log[4]), 32'd1);
        chk("t3_sel_c9", 32'(sel_log[9]), 32'd2);
        chk("t3_sel_c10", 32'(sel_log[10]), 32'd3);
        chk("t3_sel_c12", 32'(sel_log[12]), 32'd3);
        step(2);

        // Back-to-back frames with a stalled consumer: the held frame survives.
        data = 4'b0110;
        dwell = 4'd1;
        frame_ready = 1'b0;
        en = 1'b1;
        step(5);
        chk("t4_valid_c5", 32'(frame_valid), 32'd1);
        chk("t4_data_c5", 32'(frame_data), 32'h6);
        chk("t4_ovr_c5", 32'(overrun), 32'd0);
        data = 4'b0001;
        step(4);
        chk("t4_ovr_c9", 32'(overrun), 32'd1);
        chk("t4_data_c9", 32'(frame_data), 32'h6);
        chk("t4_valid_c9", 32'(frame_valid), 32'd1);
        en = 1'b0;
        step(4);
        chk("t4_busy_c13", 32'(busy), 32'd0);
        chk("t4_data_c13", 32'(frame_data), 32'h6);
        frame_ready = 1'b1;
        step(1);
        chk("t4_valid_drained", 32'(frame_valid), 32'd0);
        chk("t4_ovr_sticky", 32'(overrun), 32'd1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("t4_ovr_cleared", 32'(overrun), 32'd0);

        // Handshake in the same cycle as a new commit.
        data = 4'b0110;
        dwell = 4'd1;
        frame_ready = 1'b0;
        en = 1'b1;
        step(5);
        chk("t5_data_c5", 32'(frame_data), 32'h6);
        data = 4'b1111;
        step(3);
        frame_ready = 1'b1;
        en = 1'b0;
        step(1);
        chk("t5_data_c9", 32'(frame_data), 32'hF);
        chk("t5_valid_c9", 32'(frame_valid), 32'd1);
        chk("t5_ovr_c9", 32'(overrun), 32'd0);
        step(1);
        chk("t5_valid_c10", 32'(frame_valid), 32'd0);
        step(2);

        // Per-cycle pattern on channel 0 over a dwell of 3.
        ovr = 1'b1;
        run_pat(3'b101, pfv, pfd);
        chk("t6_valid_101", 32'(pfv), 32'd1);
        chk("t6_data_101", 32'(pfd), 32'h1);
        step(2);
        run_pat(3'b010, pfv, pfd);
        chk("t6_valid_010", 32'(pfv), 32'd1);
        chk("t6_data_010", 32'(pfd), 32'h0);
        ovr = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
